// File: rtl/aes_dec.sv
// Iterative AES-128 decryptor: forward key schedule into a round-key file, then one inverse round
// per clock. Optional key reuse across blocks is enabled by defining AES_DEC_KEY_CACHE_EN.
`timescale 1ns / 1ps

module aes_dec (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic [127:0] ciphertext,
  input  logic [127:0] key,
  output logic         ready,
  output logic [127:0] plaintext,
  output logic         valid_out
);

  // Byte n of each table sits at bits [2047-8n -: 8].
  localparam logic [2047:0] SboxTable = {
    256'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0,
    256'hb7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b275,
    256'h09832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cf,
    256'hd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2,
    256'hcd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdb,
    256'he0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08,
    256'hba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9e,
    256'he1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] InvSboxTable = {
    256'h52096ad53036a538bf40a39e81f3d7fb7ce339829b2fff87348e4344c4dee9cb,
    256'h547b9432a6c2233dee4c950b42fac34e082ea16628d924b2765ba2496d8bd125,
    256'h72f8f66486689816d4a45ccc5d65b6926c704850fdedb9da5e154657a78d9d84,
    256'h90d8ab008cbcd30af7e45805b8b34506d02c1e8fca3f0f02c1afbd0301138a6b,
    256'h3a9111414f67dcea97f2cfcef0b4e67396ac7422e7ad3585e2f937e81c75df6e,
    256'h47f11a711d29c5896fb7620eaa18be1bfc563e4bc6d279209adbc0fe78cd5af4,
    256'h1fdda8338807c731b11210592780ec5f60517fa919b54a0d2de57a9f93c99cef,
    256'ha0e03b4dae2af5b0c8ebbb3c83539961172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SboxTable[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return InvSboxTable[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] m11 [4];
    logic [7:0] m13 [4];
    logic [7:0] m14 [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]   = col[31-8*i -: 8];
      x2     = xtime(a[i]);
      x4     = xtime(x2);
      x8     = xtime(x4);
      m9[i]  = x8 ^ a[i];
      m11[i] = x8 ^ x2 ^ a[i];
      m13[i] = x8 ^ x4 ^ a[i];
      m14[i] = x8 ^ x4 ^ x2;
    end
    return {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
            m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
            m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
            m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    unique case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  typedef enum logic [2:0] {StIdle, StExpand, StInit, StRound, StFinal} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q;
  logic [127:0]  ct_q, st_q, pt_q;
  logic [127:0]  rk_q [11];
  logic          valid_q;
  logic          hit;
  logic          cap, rk_we, ld_init, ld_round, ld_final;
  logic [127:0]  rk_prev, rk_new;
  logic [31:0]   rot_sub;
  logic [127:0]  sr, isb, ark, imc;

`ifdef AES_DEC_KEY_CACHE_EN
  logic [127:0] ckey_q;
  logic         cvld_q;
  assign hit = cvld_q && (key == ckey_q);
`else
  assign hit = 1'b0;
`endif

  // Forward key schedule step producing rk[cnt] from rk[cnt-1].
  always_comb begin
    rk_prev = rk_q[cnt_q - 4'd1];
    rot_sub = {sbox(rk_prev[23:16]), sbox(rk_prev[15:8]), sbox(rk_prev[7:0]),
               sbox(rk_prev[31:24])} ^ {rcon(cnt_q), 24'h0};
    rk_new[127:96] = rk_prev[127:96] ^ rot_sub;
    rk_new[95:64]  = rk_prev[95:64] ^ rk_new[127:96];
    rk_new[63:32]  = rk_prev[63:32] ^ rk_new[95:64];
    rk_new[31:0]   = rk_prev[31:0] ^ rk_new[63:32];
  end

  // Inverse round; in FINAL cnt_q has reached 0, so rk_q[cnt_q] is rk[0].
  always_comb begin
    sr = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[127-8*(4*c+r) -: 8] = st_q[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
    isb = '0;
    for (int i = 0; i < 16; i++) begin
      isb[127-8*i -: 8] = inv_sbox(sr[127-8*i -: 8]);
    end
    ark = isb ^ rk_q[cnt_q];
    imc = '0;
    for (int c = 0; c < 4; c++) begin
      imc[127-32*c -: 32] = inv_mix(ark[127-32*c -: 32]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (enable) state_d = hit ? StInit : StExpand;
      StExpand: if (cnt_q == 4'd10) state_d = StInit;
      StInit:   state_d = StRound;
      StRound:  if (cnt_q == 4'd1) state_d = StFinal;
      StFinal:  state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    ready    = 1'b0;
    cap      = 1'b0;
    rk_we    = 1'b0;
    ld_init  = 1'b0;
    ld_round = 1'b0;
    ld_final = 1'b0;
    unique case (state_q)
      StIdle: begin
        ready = 1'b1;
        cap   = enable;
      end
      StExpand: rk_we    = 1'b1;
      StInit:   ld_init  = 1'b1;
      StRound:  ld_round = 1'b1;
      StFinal:  ld_final = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      ct_q    <= '0;
      st_q    <= '0;
      pt_q    <= '0;
      valid_q <= 1'b0;
      for (int i = 0; i < 11; i++) rk_q[i] <= '0;
    end else begin
      valid_q <= ld_final;
      if (cap) begin
        ct_q     <= ciphertext;
        rk_q[0]  <= key;  // on a cache hit this rewrites the identical key
        cnt_q    <= 4'd1;
      end else if (rk_we) begin
        rk_q[cnt_q] <= rk_new;
        cnt_q       <= cnt_q + 4'd1;
      end else if (ld_init) begin
        st_q  <= ct_q ^ rk_q[10];
        cnt_q <= 4'd9;
      end else if (ld_round) begin
        st_q  <= imc;
        cnt_q <= cnt_q - 4'd1;
      end else if (ld_final) begin
        pt_q <= ark;
      end
    end
  end

`ifdef AES_DEC_KEY_CACHE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ckey_q <= '0;
      cvld_q <= 1'b0;
    end else if (rk_we && cnt_q == 4'd10) begin
      ckey_q <= rk_q[0];
      cvld_q <= 1'b1;
    end
  end
`endif

  assign plaintext = pt_q;
  assign valid_out = valid_q;

endmodule

// File: tb/tb_aes_dec.sv
// Randomized bench for aes_dec against a forward-AES reference: random plaintexts are encrypted
// by the model and the DUT must recover them, plus FIPS-197 / SP800-38A known answers.
`timescale 1ns / 1ps

module tb_aes_dec;

`ifdef AES_DEC_KEY_CACHE_EN
  localparam bit CacheEn = 1'b1;
`else
  localparam bit CacheEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         enable = 1'b0;
  logic [127:0] ciphertext = '0;
  logic [127:0] key = '0;
  logic         ready;
  logic [127:0] plaintext;
  logic         valid_out;

  aes_dec dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .ciphertext(ciphertext),
    .key       (key),
    .ready     (ready),
    .plaintext (plaintext),
    .valid_out (valid_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  logic [7:0] sb [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse in GF(2^8), then the affine map.
  task automatic build_sbox();
    logic [7:0] inv, b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      b = inv;
      sb[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] k);
    logic [31:0] w [44];
    logic [7:0]  a [16];
    logic [7:0]  t [16];
    logic [31:0] tmp;
    logic [7:0]  rc, x0, x1, x2, x3;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int j = 0; j < 16; j++) a[j] = pt[127-8*j -: 8] ^ w[j/4][31-8*(j%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int j = 0; j < 16; j++) t[j] = sb[a[j]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) a[r+4*c] = t[r+4*((c+r)%4)];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          x0 = a[4*c]; x1 = a[4*c+1]; x2 = a[4*c+2]; x3 = a[4*c+3];
          a[4*c]   = gmul(x0, 8'h02) ^ gmul(x1, 8'h03) ^ x2 ^ x3;
          a[4*c+1] = x0 ^ gmul(x1, 8'h02) ^ gmul(x2, 8'h03) ^ x3;
          a[4*c+2] = x0 ^ x1 ^ gmul(x2, 8'h02) ^ gmul(x3, 8'h03);
          a[4*c+3] = gmul(x0, 8'h03) ^ x1 ^ x2 ^ gmul(x3, 8'h02);
        end
      end
      for (int j = 0; j < 16; j++) a[j] = a[j] ^ w[4*rnd + j/4][31-8*(j%4) -: 8];
    end
    for (int j = 0; j < 16; j++) res[127-8*j -: 8] = a[j];
    return res;
  endfunction

  function automatic logic [127:0] r128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  logic [127:0] last_pt = '0;
  logic [127:0] cache_key = '0;
  bit           cache_ok = 1'b0;

  // One block: waits for ready, issues enable, optionally pokes enable mid-flight, then checks
  // latency and result. Returns #1 after the valid edge so the next call can go back-to-back.
  task automatic run_block(input string tag, input logic [127:0] ct, input logic [127:0] k,
                           input logic [127:0] pt, input bit poke);
    int n, lat;
    bit seen;
    lat = (CacheEn && cache_ok && k == cache_key) ? 11 : 21;
    for (int w = 0; w < 60 && !ready; w++) begin
      @(posedge clk);
      #1;
    end
    check({tag, "_ready"}, 128'(ready), 128'(1));
    check({tag, "_hold"}, plaintext, last_pt);
    ciphertext = ct;
    key        = k;
    enable     = 1'b1;
    @(posedge clk);
    #1;
    enable     = 1'b0;
    ciphertext = r128();
    key        = r128();
    check({tag, "_pulse"}, 128'(valid_out), 128'(0));
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      enable = poke && (n == 3 || n == lat - 4);
      if (enable) ciphertext = r128();
      @(posedge clk);
      #1;
      n++;
      seen = valid_out;
    end
    enable = 1'b0;
    check({tag, "_lat"}, 128'(n), 128'(lat));
    check({tag, "_pt"}, plaintext, pt);
    if (seen && lat == 21) begin
      cache_ok  = 1'b1;
      cache_key = k;
    end
    last_pt = pt;
  endtask

  localparam logic [127:0] KeyC1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CtC1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PtC1   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KeyEcb = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [127:0] pt, k;
    bit seen;
    build_sbox();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 128'(ready), 128'(1));
    check("rst_valid", 128'(valid_out), 128'(0));
    check("rst_pt", plaintext, '0);
    @(negedge clk);
    rst_n = 1'b1;

    run_block("c1", CtC1, KeyC1, PtC1, 1'b0);
    run_block("ecb1", 128'h3ad77bb40d7a3660a89ecaf32466ef97, KeyEcb,
              128'h6bc1bee22e409f96e93d7e117393172a, 1'b0);
    run_block("ecb2", 128'hf5d3d58503b9699de785895a96fdbaaf, KeyEcb,
              128'hae2d8a571e03ac9c9eb76fac45af8e51, 1'b0);
    run_block("zero", 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, '0, '0, 1'b0);
    run_block("c1_poke", CtC1, KeyC1, PtC1, 1'b1);
    run_block("c1_hit_poke", CtC1, KeyC1, PtC1, 1'b1);

    // Abort a block with reset at its 15th edge.
    ciphertext = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    key        = KeyEcb;
    enable     = 1'b1;
    @(posedge clk);
    #1;
    enable = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_ready", 128'(ready), 128'(1));
    check("abort_valid", 128'(valid_out), 128'(0));
    check("abort_pt", plaintext, '0);
    @(negedge clk);
    rst_n     = 1'b1;
    cache_ok  = 1'b0;
    last_pt   = '0;
    seen      = 1'b0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (valid_out) seen = 1'b1;
    end
    check("abort_novalid", 128'(seen), 128'(0));
    run_block("post_abort", CtC1, KeyC1, PtC1, 1'b0);

    k = r128();
    for (int i = 0; i < 10; i++) begin
      pt = r128();
      if (i > 0 && $urandom_range(0, 2) == 0) k = r128();
      run_block("rnd", aes_enc(pt, k), k, pt, (i % 3) == 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
